// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e      : arbiter FSM state (ST_IDLE may serve debug, ST_ACK acknowledges it)
//   DMEM_ADDR_W  : default word-address width (byte address bits [7:2])
//   DMEM_DATA_W  : default data width
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 6;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory (combinational read,
// write on the rising edge). The CPU MEM stage has priority; a debug/loader port is
// served when the CPU is idle, or pre-empts the CPU once it has waited MAX_WAIT cycles.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      MEM-stage access request
//   cpu_rdata                  read data to MEM stage (straight from mem_rdata)
//   cpu_stall                  MEM-stage access not performed this cycle
//   dbg_req/we/addr/wdata      debug request, held until dbg_ack
//   dbg_ack                    one-cycle completion pulse
//   dbg_rdata                  registered debug read data, valid with dbg_ack
//   mem_we/addr/wdata          memory write port and address
//   mem_rdata                  memory combinational read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic force_dbg;
  logic sel_dbg;

  // Debug pre-empts the CPU only once it has been refused MAX_WAIT times.
  assign force_dbg = (wait_cnt_q == CntW'(MAX_WAIT));
  assign sel_dbg   = (state_q == ST_IDLE) && dbg_req && (!cpu_req || force_dbg);

  // ---------------------------------------------------------------------------
  // FSM and starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_dbg) begin
          state_d    = ST_ACK;
          wait_cnt_d = '0;
        end else if (!dbg_req) begin
          wait_cnt_d = '0;
        end else if (!force_dbg) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      // A request still high here is a new one; it competes from the next cycle.
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered debug outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_ack_q <= sel_dbg;
      // Writes leave the last read value in place.
      if (sel_dbg && !dbg_we) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

  // ---------------------------------------------------------------------------
  // Memory mux and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req && cpu_we;
    if (sel_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end
    // Nothing may be written while reset is held, even mid-access.
    if (!reset) begin
      mem_we = 1'b0;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = reset && cpu_req && sel_dbg;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  // Memory model: combinational read, write on rising edge.
  logic [DW-1:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd7; cpu_wdata = 32'h1111_2222;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", dbg_ack); end
    n_cmp++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", dbg_rdata); end
    n_cmp++; if (mem[7] !== 32'h0) begin n_err++; $display("FAIL reset_no_write got %h want 0", mem[7]); end
    step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rel_mem_we got %b want 1", mem_we); end
    step();
    n_cmp++; if (mem[7] !== 32'h1111_2222) begin n_err++; $display("FAIL rel_write got %h want 11112222", mem[7]); end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_idle_write_read();
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd5; dbg_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);  // write: dbg_rdata keeps its reset value
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL iw_mem_we got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 6'd5) begin n_err++; $display("FAIL iw_addr got %0d want 5", mem_addr); end
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL iw_ack_early got %b want 0", dbg_ack); end
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b1) begin n_err++; $display("FAIL iw_ack got %b want 1", dbg_ack); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL iw_sb got empty want entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (dbg_rdata !== exp_v) begin n_err++; $display("FAIL iw_rdata got %h want %h", dbg_rdata, exp_v); end
    end
    n_cmp++; if (mem[5] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL iw_mem got %h want deadbeef", mem[5]); end
    step();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ir_mem_we got %b want 0", mem_we); end
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b1) begin n_err++; $display("FAIL ir_ack got %b want 1", dbg_ack); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL ir_sb got empty want entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (dbg_rdata !== exp_v) begin n_err++; $display("FAIL ir_rdata got %h want %h", dbg_rdata, exp_v); end
    end
    step();
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL ir_ack_pulse got %b want 0", dbg_ack); end
  endtask

  task automatic test_collision();
    mem[3] = 32'hCAFE_0003;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd9;
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL col_stall got %b want 0", cpu_stall); end
    n_cmp++; if (mem_addr !== 6'd3) begin n_err++; $display("FAIL col_addr got %0d want 3", mem_addr); end
    n_cmp++; if (cpu_rdata !== 32'hCAFE_0003) begin n_err++; $display("FAIL col_rdata got %h want cafe0003", cpu_rdata); end
    step();
    @(negedge clk);
    n_cmp++; if (dut.wait_cnt_q !== 3'd1) begin n_err++; $display("FAIL col_wait got %0d want 1", dut.wait_cnt_q); end
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL col_ack got %b want 0", dbg_ack); end
    step();
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();
    n_cmp++; if (dut.wait_cnt_q !== 3'd0) begin n_err++; $display("FAIL col_clear got %0d want 0", dut.wait_cnt_q); end
  endtask

  task automatic test_starvation();
    mem[10] = 32'hA5A5_000A;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd10;
    exp_q.push_back(32'hA5A5_000A);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        cpu_we = 1'b1; cpu_addr = 6'd12; cpu_wdata = 32'h0C0C_0C0C;
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_stall !== (k == 5)) begin n_err++; $display("FAIL starve_stall_c%0d got %b want %b", k, cpu_stall, k == 5); end
      n_cmp++;
      if (mem_addr !== ((k == 5) ? 6'd10 : 6'd3)) begin n_err++; $display("FAIL starve_addr_c%0d got %0d", k, mem_addr); end
      n_cmp++;
      if (dut.wait_cnt_q !== 3'(k - 1)) begin n_err++; $display("FAIL starve_wait_c%0d got %0d want %0d", k, dut.wait_cnt_q, k - 1); end
      step();
    end
    dbg_req = 1'b0;
    n_cmp++; if (mem[12] !== 32'h0) begin n_err++; $display("FAIL starve_no_cpu_wr got %h want 0", mem[12]); end
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b1) begin n_err++; $display("FAIL starve_ack got %b want 1", dbg_ack); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_ack_stall got %b want 0", cpu_stall); end
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 6'd12) begin n_err++; $display("FAIL starve_cpu_retry got we=%b addr=%0d want we=1 addr=12", mem_we, mem_addr); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL starve_sb got empty want entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (dbg_rdata !== exp_v) begin n_err++; $display("FAIL starve_rdata got %h want %h", dbg_rdata, exp_v); end
    end
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    n_cmp++; if (mem[12] !== 32'h0C0C_0C0C) begin n_err++; $display("FAIL starve_cpu_wr got %h want 0c0c0c0c", mem[12]); end
  endtask

  task automatic test_back_to_back();
    step();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd20; dbg_wdata = 32'h2020_2020;
    exp_q.push_back(32'hA5A5_000A);  // write keeps the previous read value
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 6'd20) begin n_err++; $display("FAIL b2b_t got we=%b addr=%0d want 1/20", mem_we, mem_addr); end
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3;
    dbg_we = 1'b0;
    exp_q.push_back(32'h2020_2020);
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack1 got %b want 1", dbg_ack); end
    n_cmp++; if (cpu_stall !== 1'b0 || mem_addr !== 6'd3) begin n_err++; $display("FAIL b2b_ack1_cpu got stall=%b addr=%0d want 0/3", cpu_stall, mem_addr); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_sb1 got empty want entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (dbg_rdata !== exp_v) begin n_err++; $display("FAIL b2b_rdata1 got %h want %h", dbg_rdata, exp_v); end
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b0 || mem_addr !== 6'd20 || mem_we !== 1'b0) begin n_err++; $display("FAIL b2b_t2 got ack=%b addr=%0d we=%b want 0/20/0", dbg_ack, mem_addr, mem_we); end
    step();
    cpu_req = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL b2b_ack2 got ack=%b stall=%b want 1/0", dbg_ack, cpu_stall); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_sb2 got empty want entry"); end
    else begin
      exp_v = exp_q.pop_front();
      if (dbg_rdata !== exp_v) begin n_err++; $display("FAIL b2b_rdata2 got %h want %h", dbg_rdata, exp_v); end
    end
    step();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd30; dbg_wdata = 32'h3030_3030;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rma_sel got %b want 1", mem_we); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rma_mem_we got %b want 0", mem_we); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL rma_ack got %b want 0", dbg_ack); end
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rma_state got %b want 0", dut.state_q); end
    n_cmp++; if (dut.wait_cnt_q !== 3'd0) begin n_err++; $display("FAIL rma_wait got %0d want 0", dut.wait_cnt_q); end
    n_cmp++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL rma_rdata got %h want 0", dbg_rdata); end
    step();
    dbg_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL rma_post_ack got %b want 0", dbg_ack); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rma_sb got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_idle_write_read();
    test_collision();
    test_starvation();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter for the single-ported data memory, which has a combinational read and a write on the clock edge. It sits between the CPU's MEM stage and the memory. A second requester, the debug/loader port, can read and write data memory while the CPU runs. The CPU has priority, but a starvation counter guarantees the debug port service within a bounded number of cycles. When the debug port is served during a CPU access, the arbiter asserts a stall toward the pipeline.

## Interface
Parameters:
- ADDR_W, 6: word address width (byte address bits [7:2]).
- DATA_W, 32: data width.
- MAX_WAIT, 4: debug wait cycles before it pre-empts the CPU; legal range is ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access this cycle (MemRead or MemWrite).
- cpu_we  in  1  MEM-stage write.
- cpu_addr  in  ADDR_W  MEM-stage word address.
- cpu_wdata  in  DATA_W  MEM-stage write data.
- cpu_rdata  out  DATA_W  read data to MEM stage (combinational pass of mem_rdata).
- cpu_stall  out  1  MEM-stage access not performed this cycle; the pipeline holds EX/MEM and earlier stages.
- dbg_req  in  1  debug request; held with its fields until dbg_ack.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle pulse marking completion of a debug access.
- dbg_rdata  out  DATA_W  registered debug read data, valid while dbg_ack=1.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.

## Operation
- FSM states:
  - ST_IDLE: the debug port may be served.
  - ST_ACK: dbg_ack=1; the debug port is not served in this state.
- Select signal, combinational: sel_dbg = (state==ST_IDLE) && dbg_req && (!cpu_req || force), where force = (wait_cnt==MAX_WAIT).
- Memory mux:
  - sel_dbg=1: mem_addr/mem_wdata/mem_we come from dbg_*.
  - sel_dbg=0: they come from cpu_*, with mem_we = cpu_req && cpu_we.
- cpu_rdata = mem_rdata always.
- cpu_stall = cpu_req && sel_dbg.
- FSM transitions:
  - ST_IDLE → ST_ACK when sel_dbg. On that edge: dbg_rdata <= mem_rdata (for reads; it holds its previous value for writes); dbg_ack <= 1.
  - ST_ACK → ST_IDLE unconditionally. On that edge: dbg_ack <= 0.
- wait_cnt, width $clog2(MAX_WAIT+1):
  - Increments (saturating at MAX_WAIT) in any cycle with state==ST_IDLE && dbg_req && !sel_dbg.
  - Clears to 0 when sel_dbg, or when dbg_req=0.
  - Holds in ST_ACK.
- The debug requester must drop dbg_req in the ack cycle, or present its next request. If dbg_req is still high in ST_ACK, it is treated as a new request and is eligible from the following cycle.
- Reset (reset=0):
  - state=ST_IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0.
  - Combinational outputs are forced while reset is held: mem_we=0, cpu_stall=0.
  - Reset mid-access aborts the access with no ack; any write already clocked into memory stands.

## Timing
- CPU access latency is 0 cycles: read data is combinational, and a write commits at the end of the access cycle.
- Debug access happens in cycle t (sel_dbg=1); dbg_ack and dbg_rdata are valid in cycle t+1.
- Minimum debug request spacing is 2 cycles (access, ack).
- Worst-case debug latency from dbg_req rising to the access cycle is MAX_WAIT cycles, with the CPU requesting continuously.
- A forced pre-emption stalls the CPU for exactly 1 cycle; the CPU access repeats in the ack cycle.
- Simultaneous cpu_req and dbg_req with force=0: the CPU wins, no stall, wait_cnt increments.
- In ST_ACK the CPU is never stalled.

## Structure
- Shared package holds:
  - the state enum: ST_IDLE=1'b0, ST_ACK=1'b1;
  - the default widths: ADDR_W=6, DATA_W=32.
- No sub-modules.
- Single file with three parts: the FSM/counter always block, the registered debug outputs, and the combinational mux/stall logic.
- The CPU top instantiates the arbiter between the EX/MEM register and the memory. cpu_stall is ORed into the pipeline hold: it freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB.

## Test plan
- Reset: hold reset=0 with cpu_req=1, cpu_we=1. Required: mem_we=0, cpu_stall=0, dbg_ack=0, dbg_rdata=0. After reset release, the first edge writes.
- Idle debug write then read:
  - cpu_req=0; debug write addr=5, data=32'hDEADBEEF. Required: mem_we=1 in cycle t, dbg_ack=1 in t+1.
  - Then a debug read of addr 5. Required: dbg_rdata=32'hDEADBEEF with dbg_ack.
- Collision without force: cpu_req=1 (read, addr 3) and dbg_req=1 in the same cycle. Required: cpu_stall=0, mem_addr=3, wait_cnt=1, no ack.
- Starvation: with MAX_WAIT=4, cpu_req=1 continuously and dbg_req held. Required: the debug access occurs in the 5th cycle of the request, cpu_stall=1 for that single cycle, then ack, with the CPU served in the ack cycle.
- Back-to-back debug: dbg_req kept high through the ack. Required: accesses at t and t+2, acks at t+1 and t+3, with the CPU never stalled in ack cycles.
- Asynchronous reset mid-access: assert reset in the sel_dbg cycle before the edge. Required: dbg_ack stays 0, state returns to ST_IDLE, wait_cnt=0.
